// File: rtl/regfile_wb_queue_if.sv
// Bundle of the ALU/load result handshakes and the regfile write port.
// The forwarding lookup signals exist only when WB_FWD_EN is defined.
interface regfile_wb_queue_if #(
   parameter int DW = 64,
   parameter int AW = 5
);
   logic                 alu_valid;
   logic                 alu_ready;
   logic [AW-1:0]        alu_addr;
   logic [DW-1:0]        alu_data;
   logic                 mem_valid;
   logic                 mem_ready;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_data;
   logic                 we;
   logic [AW-1:0]        wa;
   logic [DW-1:0]        wd;
   logic [(1<<AW)-1:0]   busy;
`ifdef WB_FWD_EN
   logic [AW-1:0]        fwd_addr;
   logic                 fwd_hit;
   logic [DW-1:0]        fwd_data;

   modport master (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr,
      output alu_ready, mem_ready, we, wa, wd, busy, fwd_hit, fwd_data
   );
   modport slave (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr,
      input  alu_ready, mem_ready, we, wa, wd, busy, fwd_hit, fwd_data
   );
`else
   modport master (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
      output alu_ready, mem_ready, we, wa, wd, busy
   );
   modport slave (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
      input  alu_ready, mem_ready, we, wa, wd, busy
   );
`endif
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue: arbitrates ALU/load results, drains one registered regfile write
// per cycle and tracks per-register pending writes. WB_FWD_EN adds a forwarding lookup.
module regfile_wb_queue #(
   parameter int DW    = 64,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   regfile_wb_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NR = 1 << AW;

   typedef enum logic {SRC_ALU, SRC_MEM} src_t;

   src_t            last_grant_reg;
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg, count_next;
   logic            we_reg;
   logic [AW-1:0]   wa_reg;
   logic [DW-1:0]   wd_reg;
   logic [NR-1:0]   busy_reg, busy_next;

   logic [AW-1:0]   addr_mem [DEPTH];
   logic [DW-1:0]   data_mem [DEPTH];

   logic            full, alu_gnt, mem_gnt, push, pop, head_dup;
   logic [AW-1:0]   push_addr, head_addr;
   logic [DW-1:0]   push_data, head_data;
   logic [DEPTH-1:0] entry_valid, entry_dup;

   // A pop never frees room for a push in the same cycle: full blocks both sources.
   always_comb begin
      full      = (count_reg == CW'(DEPTH));
      alu_gnt   = !full && bus.alu_valid && (!bus.mem_valid || last_grant_reg == SRC_MEM);
      mem_gnt   = !full && bus.mem_valid && !alu_gnt;
      push_addr = alu_gnt ? bus.alu_addr : bus.mem_addr;
      push_data = alu_gnt ? bus.alu_data : bus.mem_data;
      push      = (alu_gnt || mem_gnt) && (push_addr != '0);
      pop       = (count_reg != '0);
      head_addr = addr_mem[rd_ptr_reg];
      head_data = data_mem[rd_ptr_reg];
   end

   assign bus.alu_ready = alu_gnt;
   assign bus.mem_ready = mem_gnt;

   // An entry is live when its age offset from the read pointer is below the count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PW-1:0] offset;
         assign offset          = PW'(gi) - rd_ptr_reg;
         assign entry_valid[gi] = (CW'(offset) < count_reg);
         assign entry_dup[gi]   = entry_valid[gi] && (PW'(gi) != rd_ptr_reg)
                                  && (addr_mem[gi] == head_addr);
      end
   endgenerate

   assign head_dup = |entry_dup;

   always_comb begin
      busy_next = busy_reg;
      if (pop && !head_dup)
         busy_next[head_addr] = 1'b0;
      if (push)
         busy_next[push_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_reg <= SRC_MEM;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         we_reg         <= 1'b0;
         wa_reg         <= '0;
         wd_reg         <= '0;
         busy_reg       <= '0;
      end else begin
         if (alu_gnt)
            last_grant_reg <= SRC_ALU;
         else if (mem_gnt)
            last_grant_reg <= SRC_MEM;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         we_reg    <= pop;
         if (pop) begin
            wa_reg <= head_addr;
            wd_reg <= head_data;
         end
         busy_reg <= busy_next;
      end
   end

   // Entry storage needs no reset; liveness comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= push_addr;
         data_mem[wr_ptr_reg] <= push_data;
      end
   end

   assign bus.we   = we_reg;
   assign bus.wa   = wa_reg;
   assign bus.wd   = wd_reg;
   assign bus.busy = busy_reg;

`ifdef WB_FWD_EN
   logic            fwd_hit_c;
   logic [DW-1:0]   fwd_data_c;

   // Scan oldest to youngest so the youngest matching write ends up selected.
   always_comb begin
      logic [PW-1:0] idx;
      idx        = '0;
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      if (we_reg && wa_reg == bus.fwd_addr) begin
         fwd_hit_c  = 1'b1;
         fwd_data_c = wd_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_reg + PW'(k);
         if (CW'(k) < count_reg && addr_mem[idx] == bus.fwd_addr) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = data_mem[idx];
         end
      end
      if (bus.fwd_addr == '0) begin
         fwd_hit_c  = 1'b0;
         fwd_data_c = '0;
      end
   end

   assign bus.fwd_hit  = fwd_hit_c;
   assign bus.fwd_data = fwd_data_c;
`endif
endmodule
